// File: rtl/arbitro_ocho_lineas_pkg.sv
// Shared sizing and FSM state encoding for the eight-line grant sequencer.
package arbitro_pkg;

   localparam int N_LINEAS = 8;
   localparam int ID_W     = $clog2(N_LINEAS);

   typedef enum logic [1:0] {
      LIBRE   = 2'd0,
      CONCEDE = 2'd1,
      PAUSA   = 2'd2
   } estado_t;

endpackage

// File: rtl/arbitro_ocho_lineas_if.sv
// Request/grant bundle between the arbiter (master) and its environment (slave).
interface arbitro_ocho_lineas_if;
   import arbitro_pkg::*;

   logic [N_LINEAS-1:0] ocho_lineas;
   logic [N_LINEAS-1:0] mascara;
   logic                gnt_ack;
   logic                gnt_valid;
   logic [ID_W-1:0]     gnt_id;
   logic [N_LINEAS-1:0] gnt_onehot;
   logic [N_LINEAS-1:0] pendientes;
   logic                alguno;

   modport master (
      input  ocho_lineas, mascara, gnt_ack,
      output gnt_valid, gnt_id, gnt_onehot, pendientes, alguno
   );

   modport slave (
      output ocho_lineas, mascara, gnt_ack,
      input  gnt_valid, gnt_id, gnt_onehot, pendientes, alguno
   );

endinterface

// File: rtl/arbitro_ocho_lineas_codificador_prioridad.sv
// Combinational highest-index priority encoder with a valid flag.
module codificador_prioridad
   import arbitro_pkg::*;
(
   input  logic [N_LINEAS-1:0] vec,
   output logic [ID_W-1:0]     idx,
   output logic                valid
);

   // Ascending scan: the last set bit seen is the highest index.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = 0; i < N_LINEAS; i++) begin
         if (vec[i]) begin
            idx   = ID_W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/arbitro_ocho_lineas.sv
// Eight-line sticky-request arbiter with valid/ack grant handshake.
// Define ROUND_ROBIN_EN for rotating priority; default is fixed highest-index priority.
module arbitro_ocho_lineas
   import arbitro_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   arbitro_ocho_lineas_if.master bus
);

   estado_t             state_reg, state_next;
   logic [N_LINEAS-1:0] pend_reg, pend_next;
   logic [N_LINEAS-1:0] clr;
   logic                gnt_valid_reg, gnt_valid_next;
   logic [ID_W-1:0]     gnt_id_reg, gnt_id_next;
   logic [N_LINEAS-1:0] gnt_onehot_reg, gnt_onehot_next;

   logic [N_LINEAS-1:0] candidatos;
   logic [ID_W-1:0]     win_id;
   logic                win_valid;
   logic [N_LINEAS-1:0] win_onehot;

   assign candidatos = pend_reg & ~bus.mascara;

`ifdef ROUND_ROBIN_EN
   logic [ID_W-1:0]     ptr_reg, ptr_next;
   logic [N_LINEAS-1:0] rot, rev;
   logic [ID_W-1:0]     rev_idx;

   // Rotate so ptr lands on bit 0, then reverse so the highest-index encoder
   // picks the first candidate at or above ptr; undo both afterwards.
   for (genvar gi = 0; gi < N_LINEAS; gi++) begin : g_rot
      assign rot[gi] = candidatos[ID_W'(gi) + ptr_reg];
      assign rev[gi] = rot[N_LINEAS-1-gi];
   end

   codificador_prioridad u_cod (
      .vec   (rev),
      .idx   (rev_idx),
      .valid (win_valid)
   );

   assign win_id = ptr_reg + (ID_W'(N_LINEAS-1) - rev_idx);

   always_comb begin
      ptr_next = ptr_reg;
      if (state_reg == CONCEDE && bus.gnt_ack)
         ptr_next = gnt_id_reg + ID_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) ptr_reg <= '0;
      else     ptr_reg <= ptr_next;
   end
`else
   codificador_prioridad u_cod (
      .vec   (candidatos),
      .idx   (win_id),
      .valid (win_valid)
   );
`endif

   for (genvar gi = 0; gi < N_LINEAS; gi++) begin : g_onehot
      assign win_onehot[gi] = (win_id == ID_W'(gi));
   end

   // A line still high during its ack re-pends: set beats clear.
   assign clr       = (gnt_valid_reg && bus.gnt_ack) ? gnt_onehot_reg : '0;
   assign pend_next = (pend_reg & ~clr) | bus.ocho_lineas;

   always_comb begin
      state_next      = state_reg;
      gnt_valid_next  = gnt_valid_reg;
      gnt_id_next     = gnt_id_reg;
      gnt_onehot_next = gnt_onehot_reg;
      case (state_reg)
         LIBRE: begin
            if (win_valid) begin
               gnt_valid_next  = 1'b1;
               gnt_id_next     = win_id;
               gnt_onehot_next = win_onehot;
               state_next      = CONCEDE;
            end
         end
         CONCEDE: begin
            if (bus.gnt_ack) begin
               gnt_valid_next  = 1'b0;
               gnt_onehot_next = '0;
               state_next      = PAUSA;
            end
         end
         PAUSA:   state_next = LIBRE;
         default: state_next = LIBRE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= LIBRE;
         pend_reg       <= '0;
         gnt_valid_reg  <= 1'b0;
         gnt_id_reg     <= '0;
         gnt_onehot_reg <= '0;
      end else begin
         state_reg      <= state_next;
         pend_reg       <= pend_next;
         gnt_valid_reg  <= gnt_valid_next;
         gnt_id_reg     <= gnt_id_next;
         gnt_onehot_reg <= gnt_onehot_next;
      end
   end

   assign bus.gnt_valid  = gnt_valid_reg;
   assign bus.gnt_id     = gnt_id_reg;
   assign bus.gnt_onehot = gnt_onehot_reg;
   assign bus.pendientes = pend_reg;
   assign bus.alguno     = |candidatos;

endmodule

// File: tb/tb_arbitro_ocho_lineas.sv
// Bench for arbitro_ocho_lineas: per-cycle vector table plus a back-to-back grant sequence.
module tb_arbitro_ocho_lineas;
   import arbitro_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   arbitro_ocho_lineas_if arb();

   arbitro_ocho_lineas dut (
      .clk (clk),
      .rst (rst),
      .bus (arb)
   );

   typedef struct {
      logic       r;
      logic [7:0] lin;
      logic [7:0] msk;
      logic       ack;
      logic       v;
      logic [2:0] id;
      logic [7:0] oh;
      logic [7:0] pend;
      logic       alg;
   } vec_t;

   vec_t       tbl [64];
   int         n_vec = 0;
   vec_t       sb_q [$];
   logic [2:0] gq [$];
   int         total = 0;
   int         bad   = 0;

   task automatic add(input logic r, input logic [7:0] lin, input logic [7:0] msk,
                      input logic ack, input logic v, input logic [2:0] id,
                      input logic [7:0] oh, input logic [7:0] pend, input logic alg);
      tbl[n_vec].r    = r;
      tbl[n_vec].lin  = lin;
      tbl[n_vec].msk  = msk;
      tbl[n_vec].ack  = ack;
      tbl[n_vec].v    = v;
      tbl[n_vec].id   = id;
      tbl[n_vec].oh   = oh;
      tbl[n_vec].pend = pend;
      tbl[n_vec].alg  = alg;
      n_vec++;
   endtask

   task automatic chk(input string name, input int step, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at step %0d: got %0h, expected %0h", name, step, act, exp);
      end
   endtask

   initial begin
      vec_t       e;
      logic [2:0] exp_id;
      int         waited;

      rst             = 1'b1;
      arb.ocho_lineas = 8'h00;
      arb.mascara     = 8'h00;
      arb.gnt_ack     = 1'b0;

`ifndef ROUND_ROBIN_EN
      // reset with all lines high, then first grant
      add(1, 8'hFF, 8'h00, 0,  0, 3'd0, 8'h00, 8'h00, 0);
      add(1, 8'hFF, 8'h00, 0,  0, 3'd0, 8'h00, 8'h00, 0);
      add(0, 8'hFF, 8'h00, 0,  0, 3'd0, 8'h00, 8'hFF, 1);
      add(0, 8'h00, 8'h00, 0,  1, 3'd7, 8'h80, 8'hFF, 1);
      add(0, 8'h00, 8'h00, 1,  0, 3'd7, 8'h00, 8'h7F, 1);
      add(0, 8'h00, 8'h00, 0,  0, 3'd7, 8'h00, 8'h7F, 1);
      add(0, 8'h00, 8'h00, 0,  1, 3'd6, 8'h40, 8'h7F, 1);
      // reset while granting, then a stray ack
      add(1, 8'h00, 8'h00, 0,  0, 3'd0, 8'h00, 8'h00, 0);
      add(0, 8'h00, 8'h00, 1,  0, 3'd0, 8'h00, 8'h00, 0);
      // one-cycle pulse on lines 5 and 2
      add(0, 8'h24, 8'h00, 0,  0, 3'd0, 8'h00, 8'h24, 1);
      add(0, 8'h00, 8'h00, 0,  1, 3'd5, 8'h20, 8'h24, 1);
      add(0, 8'h00, 8'h00, 1,  0, 3'd5, 8'h00, 8'h04, 1);
      add(0, 8'h00, 8'h00, 0,  0, 3'd5, 8'h00, 8'h04, 1);
      add(0, 8'h00, 8'h00, 0,  1, 3'd2, 8'h04, 8'h04, 1);
      add(0, 8'h00, 8'h00, 1,  0, 3'd2, 8'h00, 8'h00, 0);
      add(0, 8'h00, 8'h00, 0,  0, 3'd2, 8'h00, 8'h00, 0);
      // masked line 7 stays pending but is never granted until unmasked
      add(0, 8'h81, 8'h80, 0,  0, 3'd2, 8'h00, 8'h81, 1);
      add(0, 8'h00, 8'h80, 0,  1, 3'd0, 8'h01, 8'h81, 1);
      add(0, 8'h00, 8'h80, 1,  0, 3'd0, 8'h00, 8'h80, 0);
      add(0, 8'h00, 8'h80, 0,  0, 3'd0, 8'h00, 8'h80, 0);
      add(0, 8'h00, 8'h80, 0,  0, 3'd0, 8'h00, 8'h80, 0);
      add(0, 8'h00, 8'h00, 0,  1, 3'd7, 8'h80, 8'h80, 1);
      // long-held grant while line 6 arrives and the mask toggles
      add(0, 8'h40, 8'h00, 0,  1, 3'd7, 8'h80, 8'hC0, 1);
      for (int k = 0; k < 19; k++)
         add(0, 8'h00, (k >= 5 && k < 10) ? 8'h80 : 8'h00, 0, 1, 3'd7, 8'h80, 8'hC0, 1);
      add(0, 8'h00, 8'h00, 1,  0, 3'd7, 8'h00, 8'h40, 1);
      add(0, 8'h00, 8'h00, 0,  0, 3'd7, 8'h00, 8'h40, 1);
      add(0, 8'h00, 8'h00, 0,  1, 3'd6, 8'h40, 8'h40, 1);
      add(0, 8'h00, 8'h00, 1,  0, 3'd6, 8'h00, 8'h00, 0);
      add(0, 8'h00, 8'h00, 0,  0, 3'd6, 8'h00, 8'h00, 0);

      for (int s = 0; s < n_vec; s++) begin
         rst             = tbl[s].r;
         arb.ocho_lineas = tbl[s].lin;
         arb.mascara     = tbl[s].msk;
         arb.gnt_ack     = tbl[s].ack;
         sb_q.push_back(tbl[s]);
         @(posedge clk);
         #1;
         e = sb_q.pop_front();
         chk("gnt_valid",  s, 32'(arb.gnt_valid),  32'(e.v));
         chk("gnt_id",     s, 32'(arb.gnt_id),     32'(e.id));
         chk("gnt_onehot", s, 32'(arb.gnt_onehot), 32'(e.oh));
         chk("pendientes", s, 32'(arb.pendientes), 32'(e.pend));
         chk("alguno",     s, 32'(arb.alguno),     32'(e.alg));
         $display("step %0d rst=%0b lin=%h msk=%h ack=%0b -> valid=%0b id=%0d onehot=%h pend=%h alguno=%0b",
                  s, tbl[s].r, tbl[s].lin, tbl[s].msk, tbl[s].ack, arb.gnt_valid,
                  arb.gnt_id, arb.gnt_onehot, arb.pendientes, arb.alguno);
      end
`endif

      // all lines held high, every grant acked at once
      rst             = 1'b1;
      arb.ocho_lineas = 8'hFF;
      arb.mascara     = 8'h00;
      arb.gnt_ack     = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_valid", -1, 32'(arb.gnt_valid), 32'd0);
      rst = 1'b0;
      for (int g = 0; g < 9; g++) begin
`ifdef ROUND_ROBIN_EN
         gq.push_back(3'(g));
`else
         gq.push_back(3'd7);
`endif
      end

      for (int g = 0; g < 9; g++) begin
         waited = 0;
         while (!arb.gnt_valid && waited < 12) begin
            @(posedge clk);
            #1;
            waited++;
         end
         if (!arb.gnt_valid) begin
            total++;
            bad++;
            $display("FAIL grant_timeout at grant %0d: gnt_valid got 0, expected 1", g);
            break;
         end
         exp_id = gq.pop_front();
         chk("seq_gnt_id",     g, 32'(arb.gnt_id),     32'(exp_id));
         chk("seq_gnt_onehot", g, 32'(arb.gnt_onehot), 32'(8'h01 << exp_id));
         chk("seq_gap",        g, 32'(waited),         32'd2);
         $display("grant %0d id=%0d onehot=%h after %0d cycles", g, arb.gnt_id,
                  arb.gnt_onehot, waited);
         arb.gnt_ack = 1'b1;
         @(posedge clk);
         #1;
         arb.gnt_ack = 1'b0;
         chk("seq_valid_after_ack", g, 32'(arb.gnt_valid),  32'd0);
         chk("seq_pend_set_wins",   g, 32'(arb.pendientes), 32'hFF);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
